// File: rtl/simple_core_top.sv
// Minimal multi-cycle RV32I core with private ITCM/DTCM word SRAMs.
// Instructions retire in 4 cycles (5 for loads/stores); ECALL/EBREAK halts until reset.

module simple_core_gnrl_ram #(
    parameter int unsigned AW = 13
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [3:0]    wem,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] mem_r [0:DEPTH-1];

    // Synchronous single-port word RAM with byte write enables; no reset.
    always_ff @(posedge clk) begin
        if (cs) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (wem[i]) mem_r[addr][8*i +: 8] <= din[8*i +: 8];
                end
            end else begin
                dout <= mem_r[addr];
            end
        end
    end
endmodule

module simple_core_itcm_ram #(
    parameter int unsigned AW = 13
) (
    input  logic          clk,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [31:0]   dout
);
    simple_core_gnrl_ram #(.AW(AW)) u_itcm_gnrl_ram (
        .clk  (clk),
        .cs   (cs),
        .we   (1'b0),
        .wem  (4'b0000),
        .addr (addr),
        .din  (32'h0),
        .dout (dout)
    );
endmodule

module simple_core_dtcm_ram #(
    parameter int unsigned AW = 13
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [3:0]    wem,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);
    simple_core_gnrl_ram #(.AW(AW)) u_dtcm_gnrl_ram (
        .clk  (clk),
        .cs   (cs),
        .we   (we),
        .wem  (wem),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );
endmodule

module simple_core_srams #(
    parameter int unsigned ITCM_AW = 13,
    parameter int unsigned DTCM_AW = 13
) (
    input  logic               clk,
    input  logic               itcm_cs,
    input  logic [ITCM_AW-1:0] itcm_addr,
    output logic [31:0]        itcm_rdata,
    input  logic               dtcm_cs,
    input  logic               dtcm_we,
    input  logic [3:0]         dtcm_be,
    input  logic [DTCM_AW-1:0] dtcm_addr,
    input  logic [31:0]        dtcm_wdata,
    output logic [31:0]        dtcm_rdata
);
    simple_core_itcm_ram #(.AW(ITCM_AW)) u_itcm_ram (
        .clk  (clk),
        .cs   (itcm_cs),
        .addr (itcm_addr),
        .dout (itcm_rdata)
    );

    simple_core_dtcm_ram #(.AW(DTCM_AW)) u_dtcm_ram (
        .clk  (clk),
        .cs   (dtcm_cs),
        .we   (dtcm_we),
        .wem  (dtcm_be),
        .addr (dtcm_addr),
        .din  (dtcm_wdata),
        .dout (dtcm_rdata)
    );
endmodule

module simple_core_core #(
    parameter int unsigned PC_SIZE = 32,
    parameter int unsigned ITCM_AW = 13,
    parameter int unsigned DTCM_AW = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_SIZE-1:0] pc_rtvec,
    output logic               itcm_cs_c,
    output logic [ITCM_AW-1:0] itcm_addr,
    input  logic [31:0]        itcm_rdata,
    output logic               dtcm_cs_c,
    output logic               dtcm_we_c,
    output logic [3:0]         dtcm_be_c,
    output logic [DTCM_AW-1:0] dtcm_addr,
    output logic [31:0]        dtcm_wdata_c,
    input  logic [31:0]        dtcm_rdata
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    state_t             state, state_nxt;
    logic [PC_SIZE-1:0] pc, npc;
    logic [31:0]        ir, rs1_val, rs2_val, alu_res;
    logic [31:0]        regs [0:31];
    logic               rf_we_c;
    logic [31:0]        rf_wdata_c;
    logic               halted;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        is_load, is_store, is_halt_op, writes_rd;
    logic [31:0] rs1_rdata_c, rs2_rdata_c;

    assign opcode     = ir[6:0];
    assign funct3     = ir[14:12];
    assign rd         = ir[11:7];
    assign is_load    = (opcode == OPC_LOAD);
    assign is_store   = (opcode == OPC_STORE);
    assign is_halt_op = (opcode == OPC_SYSTEM) && (funct3 == 3'b000) && (ir[31:21] == 11'd0);
    assign writes_rd  = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                        (opcode == OPC_JALR) || is_load || (opcode == OPC_OPIMM) ||
                        (opcode == OPC_OP);
    assign halted     = (state == ST_HALT);

    assign itcm_addr  = pc[ITCM_AW+1:2];
    assign dtcm_addr  = alu_res[DTCM_AW+1:2];

    // Register operands are read while the fetched word is on the ITCM output.
    assign rs1_rdata_c = (itcm_rdata[19:15] == 5'd0) ? 32'd0 : regs[itcm_rdata[19:15]];
    assign rs2_rdata_c = (itcm_rdata[24:20] == 5'd0) ? 32'd0 : regs[itcm_rdata[24:20]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        itcm_cs_c = 1'b0;
        dtcm_cs_c = 1'b0;
        dtcm_we_c = 1'b0;
        rf_we_c   = 1'b0;
        unique case (state)
            ST_FETCH: begin
                itcm_cs_c = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = (is_load || is_store) ? ST_MEM : ST_WB;
            ST_MEM: begin
                dtcm_cs_c = 1'b1;
                dtcm_we_c = is_store;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                rf_we_c   = writes_rd && (rd != 5'd0);
                state_nxt = is_halt_op ? ST_HALT : ST_FETCH;
            end
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_b, alu_c, pc_x, pc_plus4, exec_res_c, exec_npc_c;
    logic [4:0]  shamt;
    logic        br_taken;

    // Execute: ALU result / memory address and next-pc selection.
    always_comb begin
        imm_i    = {{20{ir[31]}}, ir[31:20]};
        imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        imm_u    = {ir[31:12], 12'd0};
        imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        op_b     = (opcode == OPC_OP) ? rs2_val : imm_i;
        shamt    = op_b[4:0];
        pc_x     = 32'(pc);
        pc_plus4 = pc_x + 32'd4;

        alu_c = 32'd0;
        case (funct3)
            3'b000:  alu_c = ((opcode == OPC_OP) && ir[30]) ? rs1_val - op_b : rs1_val + op_b;
            3'b001:  alu_c = rs1_val << shamt;
            3'b010:  alu_c = {31'd0, $signed(rs1_val) < $signed(op_b)};
            3'b011:  alu_c = {31'd0, rs1_val < op_b};
            3'b100:  alu_c = rs1_val ^ op_b;
            3'b101:  alu_c = ir[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_c = rs1_val | op_b;
            default: alu_c = rs1_val & op_b;
        endcase

        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  br_taken = !($signed(rs1_val) < $signed(rs2_val));
            3'b110:  br_taken = (rs1_val < rs2_val);
            3'b111:  br_taken = !(rs1_val < rs2_val);
            default: br_taken = 1'b0;
        endcase

        exec_res_c = alu_c;
        exec_npc_c = pc_plus4;
        case (opcode)
            OPC_LUI:    exec_res_c = imm_u;
            OPC_AUIPC:  exec_res_c = pc_x + imm_u;
            OPC_JAL: begin
                exec_res_c = pc_plus4;
                exec_npc_c = pc_x + imm_j;
            end
            OPC_JALR: begin
                exec_res_c = pc_plus4;
                exec_npc_c = (rs1_val + imm_i) & ~32'd1;
            end
            OPC_BRANCH: exec_npc_c = br_taken ? pc_x + imm_b : pc_plus4;
            OPC_LOAD:   exec_res_c = rs1_val + imm_i;
            OPC_STORE:  exec_res_c = rs1_val + imm_s;
            default:    exec_res_c = alu_c;
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store lane steering and load extraction; misaligned low bits are ignored.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                dtcm_be_c    = 4'b0001 << alu_res[1:0];
                dtcm_wdata_c = {4{rs2_val[7:0]}};
            end
            2'b01: begin
                dtcm_be_c    = alu_res[1] ? 4'b1100 : 4'b0011;
                dtcm_wdata_c = {2{rs2_val[15:0]}};
            end
            default: begin
                dtcm_be_c    = 4'b1111;
                dtcm_wdata_c = rs2_val;
            end
        endcase

        case (alu_res[1:0])
            2'b00:   ld_byte = dtcm_rdata[7:0];
            2'b01:   ld_byte = dtcm_rdata[15:8];
            2'b10:   ld_byte = dtcm_rdata[23:16];
            default: ld_byte = dtcm_rdata[31:24];
        endcase
        ld_half = alu_res[1] ? dtcm_rdata[31:16] : dtcm_rdata[15:0];

        rf_wdata_c = alu_res;
        if (is_load) begin
            case (funct3)
                3'b000:  rf_wdata_c = {{24{ld_byte[7]}}, ld_byte};
                3'b001:  rf_wdata_c = {{16{ld_half[15]}}, ld_half};
                3'b100:  rf_wdata_c = {24'd0, ld_byte};
                3'b101:  rf_wdata_c = {16'd0, ld_half};
                default: rf_wdata_c = dtcm_rdata;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= pc_rtvec;
            npc     <= '0;
            ir      <= '0;
            rs1_val <= '0;
            rs2_val <= '0;
            alu_res <= '0;
        end else begin
            if (state == ST_DECODE) begin
                ir      <= itcm_rdata;
                rs1_val <= rs1_rdata_c;
                rs2_val <= rs2_rdata_c;
            end
            if (state == ST_EXEC) begin
                alu_res <= exec_res_c;
                npc     <= PC_SIZE'(exec_npc_c);
            end
            if ((state == ST_WB) && !is_halt_op) pc <= npc;
        end
    end

    // x0 is reset and never written, so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we_c) begin
            regs[rd] <= rf_wdata_c;
        end
    end

    logic unused_halted;
    assign unused_halted = halted;
endmodule

module simple_core_top #(
    parameter int unsigned PC_SIZE = 32,
    parameter int unsigned ITCM_AW = 13,
    parameter int unsigned DTCM_AW = 13
) (
    input logic               clk,
    input logic               rst_n,
    input logic [PC_SIZE-1:0] pc_rtvec
);
    logic               itcm_cs;
    logic [ITCM_AW-1:0] itcm_addr;
    logic [31:0]        itcm_rdata;
    logic               dtcm_cs, dtcm_we;
    logic [3:0]         dtcm_be;
    logic [DTCM_AW-1:0] dtcm_addr;
    logic [31:0]        dtcm_wdata, dtcm_rdata;

    simple_core_core #(.PC_SIZE(PC_SIZE), .ITCM_AW(ITCM_AW), .DTCM_AW(DTCM_AW)) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_rtvec     (pc_rtvec),
        .itcm_cs_c    (itcm_cs),
        .itcm_addr    (itcm_addr),
        .itcm_rdata   (itcm_rdata),
        .dtcm_cs_c    (dtcm_cs),
        .dtcm_we_c    (dtcm_we),
        .dtcm_be_c    (dtcm_be),
        .dtcm_addr    (dtcm_addr),
        .dtcm_wdata_c (dtcm_wdata),
        .dtcm_rdata   (dtcm_rdata)
    );

    simple_core_srams #(.ITCM_AW(ITCM_AW), .DTCM_AW(DTCM_AW)) u_srams (
        .clk        (clk),
        .itcm_cs    (itcm_cs),
        .itcm_addr  (itcm_addr),
        .itcm_rdata (itcm_rdata),
        .dtcm_cs    (dtcm_cs),
        .dtcm_we    (dtcm_we),
        .dtcm_be    (dtcm_be),
        .dtcm_addr  (dtcm_addr),
        .dtcm_wdata (dtcm_wdata),
        .dtcm_rdata (dtcm_rdata)
    );
endmodule

// File: tb/tb_simple_core_top.sv
// Scoreboard bench for simple_core_top: directed RV32I program with hand-computed
// register writebacks and DTCM stores, checked by monitors as the core retires them.
`timescale 1ns/1ps

module tb_simple_core_top;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_rtvec;

    int checks = 0;
    int errors = 0;

    simple_core_top dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_rtvec (pc_rtvec)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] rd; logic [31:0] val; } wb_t;
    typedef struct packed { logic [12:0] idx; logic [3:0] be; logic [31:0] data; } st_t;

    wb_t wb_q[$];
    st_t st_q[$];

    logic [31:0] prog [0:36];
    wb_t         exp_wb [0:21];
    logic [31:0] exp_regs [0:31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Writeback monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dut.u_core.rf_we_c === 1'b1) begin
            if (wb_q.size() == 0) begin
                chk("unexpected_wb_rd", 32'(dut.u_core.rd), 32'hFFFFFFFF);
            end else begin
                wb_t e;
                e = wb_q.pop_front();
                chk($sformatf("wb_x%0d", e.rd), {dut.u_core.rd, 27'd0} | 32'(dut.u_core.rf_wdata_c[26:0]),
                    {e.rd, 27'd0} | 32'(e.val[26:0]));
                chk($sformatf("wb_x%0d_full", e.rd), dut.u_core.rf_wdata_c, e.val);
            end
        end
    end

    // DTCM store monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dut.u_core.dtcm_cs_c === 1'b1 && dut.u_core.dtcm_we_c === 1'b1) begin
            if (st_q.size() == 0) begin
                chk("unexpected_store", 32'(dut.u_core.dtcm_addr), 32'hFFFFFFFF);
            end else begin
                st_t s;
                s = st_q.pop_front();
                chk("store_idx", 32'(dut.u_core.dtcm_addr), 32'(s.idx));
                chk("store_be", 32'(dut.u_core.dtcm_be_c), 32'(s.be));
                chk("store_data", dut.u_core.dtcm_wdata_c, s.data);
            end
        end
    end

    task automatic push_expectations();
        for (int i = 0; i < 22; i++) wb_q.push_back(exp_wb[i]);
        st_q.push_back('{idx: 13'd1, be: 4'b0100, data: 32'hA5A5A5A5});
        st_q.push_back('{idx: 13'd2, be: 4'b1111, data: 32'h12345678});
    endtask

    task automatic check_reset_state(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.u_core.regs[i] !== 32'd0) nz++;
        chk({tag, "_regs_nonzero"}, 32'(nz), 32'd0);
        chk({tag, "_pc"}, dut.u_core.pc, 32'h80);
        chk({tag, "_halted"}, 32'(dut.u_core.halted), 32'd0);
    endtask

    task automatic run_to_halt(input string tag);
        int cyc;
        cyc = 0;
        while (dut.u_core.halted !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_halt_reached"}, 32'(dut.u_core.halted), 32'd1);
        chk({tag, "_halt_pc"}, dut.u_core.pc, 32'h10C);
        repeat (100) @(negedge clk);
        chk({tag, "_pc_frozen"}, dut.u_core.pc, 32'h10C);
        chk({tag, "_still_halted"}, 32'(dut.u_core.halted), 32'd1);
        chk({tag, "_x0"}, dut.u_core.regs[0], 32'd0);
        chk({tag, "_x31_skipped"}, dut.u_core.regs[31], 32'd0);
        for (int i = 1; i < 31; i++) chk($sformatf("%s_final_x%0d", tag, i), dut.u_core.regs[i], exp_regs[i]);
        chk({tag, "_wb_pending"}, 32'(wb_q.size()), 32'd0);
        chk({tag, "_st_pending"}, 32'(st_q.size()), 32'd0);
        chk({tag, "_dtcm_w0"}, dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[0], 32'h000080FF);
        chk({tag, "_dtcm_w1"}, dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[1], 32'h00A50001);
        chk({tag, "_dtcm_w2"}, dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[2], 32'h12345678);
    endtask

    initial begin
        prog = '{
            32'h008000EF, 32'h00100F93, 32'h00500093, 32'hFF908113, // 0x80 jal x1,+8 / skipped / addi / addi
            32'h0020B1B3, 32'h00000203, 32'h00004303, 32'h00001283, // sltu, lb, lbu, lh
            32'h0A500393, 32'h00700323, 32'h00402403, 32'h123454B7, // addi x7, sb, lw, lui
            32'h67848493, 32'h00902423, 32'h00802503, 32'h00109463, // addi, sw, lw, bne not taken
            32'h00209463, 32'h00200F93, 32'h00000597, 32'h01558593, // bne taken, skipped, auipc, addi
            32'h00058667, 32'h00300F93, 32'h00400F93, 32'h04D00013, // jalr, skipped x2, addi x0
            32'h401106B3, 32'h40115713, 32'h01C15793, 32'h00112833, // sub, srai, srli, slt
            32'hFFF0C893, 32'h00109933, 32'h00117463, 32'h00500F93, // xori, sll, bgeu, skipped
            32'h00114463, 32'h00600F93, 32'h00005983, 32'h00000073, // blt, skipped, lhu, ecall
            32'h00700F93
        };
        exp_wb = '{
            '{5'd1,  32'h00000084}, '{5'd1,  32'h00000005}, '{5'd2,  32'hFFFFFFFE},
            '{5'd3,  32'h00000001}, '{5'd4,  32'hFFFFFFFF}, '{5'd6,  32'h000000FF},
            '{5'd5,  32'hFFFF80FF}, '{5'd7,  32'h000000A5}, '{5'd8,  32'h00A50001},
            '{5'd9,  32'h12345000}, '{5'd9,  32'h12345678}, '{5'd10, 32'h12345678},
            '{5'd11, 32'h000000C8}, '{5'd11, 32'h000000DD}, '{5'd12, 32'h000000D4},
            '{5'd13, 32'hFFFFFFF9}, '{5'd14, 32'hFFFFFFFF}, '{5'd15, 32'h0000000F},
            '{5'd16, 32'h00000001}, '{5'd17, 32'hFFFFFFFA}, '{5'd18, 32'h000000A0},
            '{5'd19, 32'h000080FF}
        };
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
        for (int i = 0; i < 22; i++) exp_regs[exp_wb[i].rd] = exp_wb[i].val;

        rst_n    = 1'b0;
        pc_rtvec = 32'h80;
        for (int i = 0; i < 37; i++) dut.u_srams.u_itcm_ram.u_itcm_gnrl_ram.mem_r[32 + i] = prog[i];
        dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[0] = 32'h000080FF;
        dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[1] = 32'h00000001;
        dut.u_srams.u_dtcm_ram.u_dtcm_gnrl_ram.mem_r[2] = 32'h00000000;

        repeat (3) @(negedge clk);
        check_reset_state("reset1");
        push_expectations();
        rst_n = 1'b1;
        #1;
        chk("first_fetch_cs", 32'(dut.u_core.itcm_cs_c), 32'd1);
        chk("first_fetch_word", 32'(dut.u_core.itcm_addr), 32'd32);
        run_to_halt("run1");

        // Reset out of HALT and re-run the same program.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("reset2");
        @(negedge clk);
        push_expectations();
        rst_n = 1'b1;
        run_to_halt("run2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
